// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for fifo_memory: read pointers, empty flag, array read
// strobe, and a 2-entry valid/ready output buffer. Optional macro FIFO_RD_LEVEL_EN.
module fifo_rd_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH:0]   rq2_wptr,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [ADDR_WIDTH:0]   rptr,
  output logic                  empty,
  output logic                  m_valid,
  input  logic                  m_ready,
`ifdef FIFO_RD_LEVEL_EN
  output logic [ADDR_WIDTH+1:0] rd_level,
`endif
  output logic [DATA_WIDTH-1:0] m_data
);

  logic [ADDR_WIDTH:0]   r_rbin;
  logic [ADDR_WIDTH:0]   r_rptr;
  logic                  r_empty;
  logic                  r_inflight;
  logic [1:0]            r_bufCnt;
  logic [DATA_WIDTH-1:0] r_buf0;
  logic [DATA_WIDTH-1:0] r_buf1;

  logic                  w_pop;
  logic [2:0]            w_occupancy;
  logic                  w_issue;
  logic [ADDR_WIDTH:0]   w_rbinNext;
  logic [ADDR_WIDTH:0]   w_rgrayNext;
  logic [1:0]            w_bufCntNext;
  logic [DATA_WIDTH-1:0] w_buf0Next;
  logic [DATA_WIDTH-1:0] w_buf1Next;

  assign m_valid = (r_bufCnt != 2'd0);
  assign m_data  = r_buf0;
  assign w_pop   = m_valid & m_ready;

  // Words already buffered or in flight after this cycle's pop; issuing only
  // when at most one remains keeps the 2-entry buffer from ever overflowing.
  assign w_occupancy = {1'b0, r_bufCnt} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue     = !r_empty && (w_occupancy <= 3'd1);

  assign mem_rd_en   = w_issue;
  assign mem_raddr   = r_rbin[ADDR_WIDTH-1:0];
  assign rptr        = r_rptr;
  assign empty       = r_empty;

  assign w_rbinNext  = r_rbin + {{ADDR_WIDTH{1'b0}}, w_issue};
  assign w_rgrayNext = w_rbinNext ^ (w_rbinNext >> 1);

  // Buffer update: r_buf0 is always the head, r_buf1 the second entry.
  always_comb begin
    w_bufCntNext = r_bufCnt;
    w_buf0Next   = r_buf0;
    w_buf1Next   = r_buf1;
    case ({r_inflight, w_pop})
      2'b10: begin
        if (r_bufCnt == 2'd0) begin
          w_buf0Next = mem_rd_data;
        end else begin
          w_buf1Next = mem_rd_data;
        end
        w_bufCntNext = r_bufCnt + 2'd1;
      end
      2'b01: begin
        w_buf0Next   = r_buf1;
        w_bufCntNext = r_bufCnt - 2'd1;
      end
      2'b11: begin
        if (r_bufCnt == 2'd1) begin
          w_buf0Next = mem_rd_data;
        end else begin
          w_buf0Next = r_buf1;
          w_buf1Next = mem_rd_data;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rbin     <= '0;
      r_rptr     <= '0;
      r_empty    <= 1'b1;
      r_inflight <= 1'b0;
      r_bufCnt   <= 2'd0;
      r_buf0     <= '0;
      r_buf1     <= '0;
    end else begin
      r_rbin     <= w_rbinNext;
      r_rptr     <= w_rgrayNext;
      r_empty    <= (w_rgrayNext == rq2_wptr);
      r_inflight <= w_issue;
      r_bufCnt   <= w_bufCntNext;
      r_buf0     <= w_buf0Next;
      r_buf1     <= w_buf1Next;
    end
  end

`ifdef FIFO_RD_LEVEL_EN
  localparam int LW = ADDR_WIDTH + 2;

  function automatic logic [ADDR_WIDTH:0] gray2bin(input logic [ADDR_WIDTH:0] g);
    logic [ADDR_WIDTH:0] b;
    b[ADDR_WIDTH] = g[ADDR_WIDTH];
    for (int i = ADDR_WIDTH - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [ADDR_WIDTH:0] w_avail;
  logic [LW-1:0]       w_levelNext;
  logic [LW-1:0]       r_level;

  // Unread words in the array plus the in-flight word plus buffered words.
  assign w_avail     = gray2bin(rq2_wptr) - w_rbinNext;
  assign w_levelNext = LW'(w_avail) + LW'(w_issue) + LW'(w_bufCntNext);
  assign rd_level    = r_level;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level <= '0;
    end else begin
      r_level <= w_levelNext;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed self-checking bench for fifo_rd_ctrl with a registered-read array
// model and a scoreboard queue; rd_level checks enabled by FIFO_RD_LEVEL_EN.
module tb_fifo_rd_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rq2_wptr;
  logic       mem_rd_en;
  logic [3:0] mem_raddr;
  logic [7:0] mem_rd_data;
  logic [4:0] rptr;
  logic       empty;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
`ifdef FIFO_RD_LEVEL_EN
  logic [5:0] rd_level;
`endif

  logic [7:0] memArray [16];
  logic [4:0] wbin;
  logic [7:0] expQ [$];
  int         vectors = 0;
  int         miscompares = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= memArray[mem_raddr];
  end

  fifo_rd_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .rq2_wptr   (rq2_wptr),
    .mem_rd_en  (mem_rd_en),
    .mem_raddr  (mem_raddr),
    .mem_rd_data(mem_rd_data),
    .rptr       (rptr),
    .empty      (empty),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
`ifdef FIFO_RD_LEVEL_EN
    .rd_level   (rd_level),
`endif
    .m_data     (m_data)
  );

  function automatic logic [4:0] toGray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [4:0] fromGray(input logic [4:0] g);
    logic [4:0] b;
    b[4] = g[4];
    for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic writeWord(input logic [7:0] value);
    memArray[wbin[3:0]] = value;
    expQ.push_back(value);
    wbin = wbin + 5'd1;
    rq2_wptr = toGray(wbin);
  endtask

  // Streams the scoreboard out while a writer adds words in random chunks,
  // never overrunning the slots the read side has freed.
  task automatic applyStimulus(input int mode, input int toWrite, input int maxCycles);
    int         cycles = 0;
    int         remaining = toWrite;
    int         space;
    int         n;
    logic [4:0] prevRptr = rptr;
    logic [7:0] expWord;
    while ((expQ.size() != 0 || remaining != 0) && cycles < maxCycles) begin
      if (remaining > 0 && $urandom_range(0, 2) == 0) begin
        space = 16 - int'(5'(wbin - fromGray(rptr)));
        n = int'($urandom_range(1, 7));
        if (n > space) n = space;
        if (n > remaining) n = remaining;
        for (int k = 0; k < n; k++) writeWord(8'($urandom_range(0, 255)));
        remaining -= n;
      end
      m_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (m_valid && m_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedValid", 32'(m_valid), 32'd0);
        end else begin
          expWord = expQ.pop_front();
          checkOutput("streamData", 32'(m_data), 32'(expWord));
        end
      end
      if (rptr != prevRptr) begin
        checkOutput("rptrOneBit", 32'($countones(rptr ^ prevRptr)), 32'd1);
        prevRptr = rptr;
      end
      tick();
      cycles++;
    end
    checkOutput("streamDrained", 32'(expQ.size() + remaining), 32'd0);
    m_ready = 1'b0;
  endtask

  initial begin
    int pulses;
    int waitCycles;
    rst = 1'b1;
    rq2_wptr = 5'd0;
    m_ready = 1'b0;
    wbin = 5'd0;
    for (int i = 0; i < 16; i++) memArray[i] = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstEmpty", 32'(empty), 32'd1);
    checkOutput("rstValid", 32'(m_valid), 32'd0);
    checkOutput("rstRptr", 32'(rptr), 32'd0);
    checkOutput("rstRdEn", 32'(mem_rd_en), 32'd0);
    checkOutput("rstData", 32'(m_data), 32'd0);
    rst = 1'b0;
    tick();

    // Single word
    memArray[0] = 8'hA5;
    wbin = 5'd1;
    rq2_wptr = toGray(wbin);
    tick();
    checkOutput("singleEmptyFall", 32'(empty), 32'd0);
    checkOutput("singleRdEn", 32'(mem_rd_en), 32'd1);
    checkOutput("singleRaddr", 32'(mem_raddr), 32'd0);
    m_ready = 1'b1;
    tick();
    checkOutput("singleRdEnOff", 32'(mem_rd_en), 32'd0);
    checkOutput("singleValidEarly", 32'(m_valid), 32'd0);
    checkOutput("singleRptr", 32'(rptr), 32'h01);
    checkOutput("singleEmptyBack", 32'(empty), 32'd1);
    tick();
    checkOutput("singleValid", 32'(m_valid), 32'd1);
    checkOutput("singleData", 32'(m_data), 32'hA5);
    tick();
    checkOutput("singleValidOnce", 32'(m_valid), 32'd0);

    // Asynchronous reset with words buffered
    m_ready = 1'b0;
    for (int k = 0; k < 3; k++) writeWord(8'h10 + 8'(k));
    repeat (4) tick();
    checkOutput("preRstValid", 32'(m_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("asyncValid", 32'(m_valid), 32'd0);
    checkOutput("asyncRptr", 32'(rptr), 32'd0);
    checkOutput("asyncEmpty", 32'(empty), 32'd1);
    checkOutput("asyncRdEn", 32'(mem_rd_en), 32'd0);
    checkOutput("asyncData", 32'(m_data), 32'd0);
    expQ.delete();
    @(negedge clk);
    wbin = 5'd0;
    rq2_wptr = 5'd0;
    tick();
    rst = 1'b0;
    tick();

    // Full burst of 16 words
    for (int i = 0; i < 16; i++) memArray[i] = 8'(i);
    wbin = 5'd16;
    rq2_wptr = toGray(wbin);
    m_ready = 1'b1;
    waitCycles = 0;
    while (!m_valid && waitCycles < 10) begin
      tick();
      waitCycles++;
    end
    checkOutput("burstStart", 32'(m_valid), 32'd1);
    for (int i = 0; i < 16; i++) begin
      checkOutput("burstValid", 32'(m_valid), 32'd1);
      checkOutput("burstData", 32'(m_data), 32'(i));
      tick();
    end
    checkOutput("burstEnd", 32'(m_valid), 32'd0);
    checkOutput("burstRptr", 32'(rptr), 32'h18);
    checkOutput("burstEmpty", 32'(empty), 32'd1);

    // Backpressure
    m_ready = 1'b0;
    for (int k = 0; k < 5; k++) writeWord(8'h40 + 8'(k));
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (mem_rd_en) pulses++;
    end
    checkOutput("bpPulses", 32'(pulses), 32'd2);
    checkOutput("bpValid", 32'(m_valid), 32'd1);
    checkOutput("bpHoldData", 32'(m_data), 32'h40);
    applyStimulus(0, 0, 40);

    // Wrap with random ready
    applyStimulus(1, 100, 3000);
    checkOutput("wrapEmpty", 32'(empty), 32'd1);
    checkOutput("wrapRptr", 32'(rptr), 32'(toGray(wbin)));

`ifdef FIFO_RD_LEVEL_EN
    // Read-level tracking
    m_ready = 1'b0;
    for (int k = 0; k < 6; k++) writeWord(8'h60 + 8'(k));
    repeat (6) tick();
    checkOutput("levelSix", 32'(rd_level), 32'd6);
    checkOutput("levelHead", 32'(m_data), 32'h60);
    m_ready = 1'b1;
    void'(expQ.pop_front());
    tick();
    m_ready = 1'b0;
    repeat (2) tick();
    checkOutput("levelFive", 32'(rd_level), 32'd5);
    checkOutput("levelNextHead", 32'(m_data), 32'h61);
    applyStimulus(0, 0, 40);
    checkOutput("levelZero", 32'(rd_level), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
